// File: rtl/wb_pkg.sv
// Shared writeback types: register-file geometry, requester indices and the buffered entry.
// Also provides the one-hot decode used by the pending-write mask.
package wb_pkg;

    localparam int unsigned REG_FILE_BITS = 5;
    localparam int unsigned REG_FILE_SIZE = 1 << REG_FILE_BITS;
    localparam int unsigned REG_SIZE      = 64;

    localparam int unsigned WB_NUM_REQ = 2;
    localparam int unsigned WB_REQ_ALU = 0;
    localparam int unsigned WB_REQ_MEM = 1;

    typedef struct packed {
        logic                     valid;
        logic [REG_FILE_BITS-1:0] num;
        logic [REG_SIZE-1:0]      data;
    } wb_entry_t;

    // One-hot of the destination register, or zero when the entry is empty
    function automatic logic [REG_FILE_SIZE-1:0] wb_onehot(input wb_entry_t e);
        wb_onehot = e.valid ? (REG_FILE_SIZE'(1) << e.num) : '0;
    endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer with valid/ready handshake.
// Writes to x0 are accepted and dropped without occupying the entry.
module wb_hold_buf
    import wb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    input  logic [REG_FILE_BITS-1:0] req_num_i,
    input  logic [REG_SIZE-1:0]      req_data_i,
    input  logic                     grant_i,
    output logic                     ready_c_o,
    output logic                     load_c_o,
    output wb_entry_t                ent_o
);

    wb_entry_t ent_q, ent_d;

    assign ready_c_o = !ent_q.valid || grant_i;
    assign load_c_o  = req_valid_i && ready_c_o && (req_num_i != '0);
    assign ent_o     = ent_q;

    // A draining entry can be replaced on the same edge it is granted
    always_comb begin
        ent_d = ent_q;
        if (load_c_o) begin
            ent_d.valid = 1'b1;
            ent_d.num   = req_num_i;
            ent_d.data  = req_data_i;
        end else if (grant_i) begin
            ent_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the ALU and load writeback buffers onto the single registered GPR write port,
// oldest entry first, and publishes the mask of registers with writes in flight.
module reg_wb_arbiter
    import wb_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [REG_FILE_BITS-1:0] req0_num,
    input  logic [REG_SIZE-1:0]      req0_data,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [REG_FILE_BITS-1:0] req1_num,
    input  logic [REG_SIZE-1:0]      req1_data,
    output logic                     we,
    output logic [REG_FILE_BITS-1:0] write_num,
    output logic [REG_SIZE-1:0]      write_data,
    output logic [REG_FILE_SIZE-1:0] pending_mask
);

    wb_entry_t             ent [WB_NUM_REQ];
    logic [WB_NUM_REQ-1:0] grant;
    logic [WB_NUM_REQ-1:0] ready;
    logic [WB_NUM_REQ-1:0] load;

    logic      old1_q, old1_d;
    wb_entry_t port_q, port_d;
    wb_entry_t winner;

    wb_hold_buf u_buf_alu (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req0_valid),
        .req_num_i   (req0_num),
        .req_data_i  (req0_data),
        .grant_i     (grant[WB_REQ_ALU]),
        .ready_c_o   (ready[WB_REQ_ALU]),
        .load_c_o    (load[WB_REQ_ALU]),
        .ent_o       (ent[WB_REQ_ALU])
    );

    wb_hold_buf u_buf_mem (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req1_valid),
        .req_num_i   (req1_num),
        .req_data_i  (req1_data),
        .grant_i     (grant[WB_REQ_MEM]),
        .ready_c_o   (ready[WB_REQ_MEM]),
        .load_c_o    (load[WB_REQ_MEM]),
        .ent_o       (ent[WB_REQ_MEM])
    );

    assign req0_ready = ready[WB_REQ_ALU];
    assign req1_ready = ready[WB_REQ_MEM];

    // Oldest-first grant; a lone valid entry wins regardless of age
    always_comb begin
        grant             = '0;
        grant[WB_REQ_MEM] = ent[WB_REQ_MEM].valid && (!ent[WB_REQ_ALU].valid || old1_q);
        grant[WB_REQ_ALU] = ent[WB_REQ_ALU].valid && (!ent[WB_REQ_MEM].valid || !old1_q);
    end

    // Simultaneous loads: the load result is older by pipeline order
    always_comb begin
        old1_d = old1_q;
        if (load[WB_REQ_ALU] && load[WB_REQ_MEM]) begin
            old1_d = 1'b1;
        end else if (load[WB_REQ_ALU] && ent[WB_REQ_MEM].valid && !grant[WB_REQ_MEM]) begin
            old1_d = 1'b1;
        end else if (load[WB_REQ_MEM] && ent[WB_REQ_ALU].valid && !grant[WB_REQ_ALU]) begin
            old1_d = 1'b0;
        end
    end

    always_comb begin
        winner = grant[WB_REQ_MEM] ? ent[WB_REQ_MEM] : ent[WB_REQ_ALU];
        port_d = port_q;
        port_d.valid = |grant;
        if (|grant) begin
            port_d.num  = winner.num;
            port_d.data = winner.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            old1_q <= 1'b0;
            port_q <= '0;
        end else begin
            old1_q <= old1_d;
            port_q <= port_d;
        end
    end

    assign we         = port_q.valid;
    assign write_num  = port_q.num;
    assign write_data = port_q.data;

    // x0 can never be pending; the mask bit is forced low for the hazard unit
    assign pending_mask = (wb_onehot(ent[WB_REQ_ALU]) | wb_onehot(ent[WB_REQ_MEM]) | wb_onehot(port_q))
                          & ~REG_FILE_SIZE'(1);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios plus a randomized run, all checked
// against an in-order queue model of in-flight writes.
module tb_reg_wb_arbiter;
    import wb_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     req0_valid, req1_valid;
    logic                     req0_ready, req1_ready;
    logic [REG_FILE_BITS-1:0] req0_num, req1_num;
    logic [REG_SIZE-1:0]      req0_data, req1_data;
    logic                     we;
    logic [REG_FILE_BITS-1:0] write_num;
    logic [REG_SIZE-1:0]      write_data;
    logic [REG_FILE_SIZE-1:0] pending_mask;

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_num     (req0_num),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_num     (req1_num),
        .req1_data    (req1_data),
        .we           (we),
        .write_num    (write_num),
        .write_data   (write_data),
        .pending_mask (pending_mask)
    );

    typedef struct {
        int                       src;
        logic [REG_FILE_BITS-1:0] num;
        logic [REG_SIZE-1:0]      data;
    } mw_t;

    // Model: queue of buffered writes in age order, plus the last port value
    mw_t                      q[$];
    logic                     we_m;
    logic [REG_FILE_BITS-1:0] num_m;
    logic [REG_SIZE-1:0]      data_m;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // A requester is ready if it has nothing queued or its entry is the oldest
    function automatic logic exp_ready(input int src);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].src == src) return (i == 0);
        end
        return 1'b1;
    endfunction

    function automatic logic [REG_FILE_SIZE-1:0] exp_mask();
        logic [REG_FILE_SIZE-1:0] m = '0;
        foreach (q[i]) m[q[i].num] = 1'b1;
        if (we_m) m[num_m] = 1'b1;
        return m;
    endfunction

    task automatic check_outputs();
        check("req0_ready", 64'(req0_ready), 64'(exp_ready(0)));
        check("req1_ready", 64'(req1_ready), 64'(exp_ready(1)));
        check("we", 64'(we), 64'(we_m));
        check("write_num", 64'(write_num), 64'(num_m));
        check("write_data", write_data, data_m);
        check("pending_mask", 64'(pending_mask), 64'(exp_mask()));
    endtask

    task automatic model_reset();
        q.delete();
        we_m   = 1'b0;
        num_m  = '0;
        data_m = '0;
    endtask

    // Called at posedge+1: drive, check before the edge, advance the model on the edge
    task automatic step(input logic v0, input logic [REG_FILE_BITS-1:0] n0, input logic [63:0] d0,
                        input logic v1, input logic [REG_FILE_BITS-1:0] n1, input logic [63:0] d1);
        logic a0, a1;
        mw_t  e;
        req0_valid = v0; req0_num = n0; req0_data = d0;
        req1_valid = v1; req1_num = n1; req1_data = d1;
        @(negedge clk);
        check_outputs();
        a0 = v0 && exp_ready(0);
        a1 = v1 && exp_ready(1);
        @(posedge clk);
        if (q.size() > 0) begin
            we_m   = 1'b1;
            num_m  = q[0].num;
            data_m = q[0].data;
            void'(q.pop_front());
        end else begin
            we_m = 1'b0;
        end
        if (a1 && n1 != '0) begin
            e.src = 1; e.num = n1; e.data = d1;
            q.push_back(e);
        end
        if (a0 && n0 != '0) begin
            e.src = 0; e.num = n0; e.data = d0;
            q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Asynchronous reset asserted mid-cycle, released before the next edge
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_num = '0; req0_data = '0;
        req1_valid = 1'b0; req1_num = '0; req1_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset with both buffers full drops both entries
        step(1'b1, 5'd9, 64'h99, 1'b1, 5'd10, 64'hAA);
        mid_reset();
        idle(3);

        // Single ALU write and its mask lifetime
        step(1'b1, 5'd5, 64'hDEAD, 1'b0, '0, '0);
        idle(3);

        // Same destination from both requesters on one edge
        step(1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2);
        idle(3);

        // Write to x0 is swallowed
        step(1'b0, '0, '0, 1'b1, 5'd0, 64'hFF);
        idle(2);

        // Back-to-back ALU stream
        for (int i = 1; i <= 8; i++) step(1'b1, 5'(i), 64'(i) * 64'h1111, 1'b0, '0, '0);
        idle(3);

        // Load buffered first, ALU arrives a cycle later, then overlapping traffic
        step(1'b0, '0, '0, 1'b1, 5'd3, 64'hA);
        step(1'b1, 5'd4, 64'hB, 1'b1, 5'd6, 64'hC);
        step(1'b1, 5'd8, 64'hD, 1'b1, 5'd9, 64'hE);
        step(1'b1, 5'd11, 64'hF, 1'b0, '0, '0);
        idle(4);

        for (int c = 0; c < 1000; c++) begin
            logic                     v0, v1;
            logic [REG_FILE_BITS-1:0] n0, n1;
            int                       pv;
            pv = (c < 500) ? 50 : 85;
            v0 = ($urandom_range(0, 99) < pv);
            v1 = ($urandom_range(0, 99) < pv);
            n0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            n1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) begin
                mid_reset();
            end else begin
                step(v0, n0, {$urandom, $urandom}, v1, n1, {$urandom, $urandom});
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
